// File: rtl/fpu_subnorm_normalizer.sv
// Subnormal operand normalizer placed after the FPU operand unpacker.
// Subnormal significands are shifted left by up to STEP bits per cycle until
// the implicit-bit position holds a 1, and the exponent is reduced to match.
// Every other operand class is registered and presented after one cycle.
module fpu_subnorm_normalizer #(
    parameter int NE   = 11,
    parameter int NF   = 52,
    parameter int STEP = 4,
    parameter int SW   = $clog2(NF + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    input  logic          InSgn,
    input  logic [NE-1:0] InExp,
    input  logic [NF:0]   InMan,
    input  logic          InSubnorm,
    input  logic          InZero,
    input  logic          InInf,
    input  logic          InNaN,
    input  logic          InSNaN,
    output logic          OutValid,
    input  logic          OutReady,
    output logic          OutSgn,
    output logic [NE:0]   OutExp,
    output logic [NF:0]   OutMan,
    output logic [SW-1:0] OutShift,
    output logic          OutSubnorm,
    output logic          OutZero,
    output logic          OutInf,
    output logic          OutNaN,
    output logic          OutSNaN
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_valid;
    logic                  r_sgn;
    logic signed [NE:0]    r_exp;
    logic [NF:0]           r_man;
    logic [SW-1:0]         r_shift;
    logic                  r_subnorm;
    logic                  r_zero;
    logic                  r_inf;
    logic                  r_nan;
    logic                  r_snan;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_needs_shift;
    logic [SW-1:0]         w_k;
    logic signed [NE:0]    w_k_ext;
    logic [NF:0]           w_man_shl;
    logic signed [NE:0]    w_exp_dec;

    // Leading zeros within the top STEP significand bits, saturating at STEP
    // when the whole window is zero.
    function automatic logic [SW-1:0] f_window_lz(input logic [NF:0] man);
        logic [SW-1:0] cnt;
        logic          found;
        cnt   = SW'(STEP);
        found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!found && man[NF-i]) begin
                cnt   = SW'(i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Handshake decode and the per-cycle shift step.
    always_comb begin
        w_in_ready    = reset_n & ~Flush &
                        ((r_state == S_IDLE) | ((r_state == S_DONE) & OutReady));
        w_accept      = InValid & w_in_ready;
        // A zero-significand subnormal would never normalize; it bypasses SHIFT.
        w_needs_shift = InSubnorm & (InMan != '0);
        w_k           = f_window_lz(r_man);
        w_k_ext       = (NE + 1)'(w_k);
        w_man_shl     = r_man << w_k;
        w_exp_dec     = r_exp - w_k_ext;
    end

    // Control FSM and operand registers; Flush outranks accept, shift and output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_sgn     <= 1'b0;
            r_exp     <= '0;
            r_man     <= '0;
            r_shift   <= '0;
            r_subnorm <= 1'b0;
            r_zero    <= 1'b0;
            r_inf     <= 1'b0;
            r_nan     <= 1'b0;
            r_snan    <= 1'b0;
        end else if (Flush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_sgn     <= InSgn;
            r_exp     <= {1'b0, InExp};
            r_man     <= InMan;
            r_shift   <= '0;
            r_subnorm <= InSubnorm;
            r_zero    <= InZero;
            r_inf     <= InInf;
            r_nan     <= InNaN;
            r_snan    <= InSNaN;
            r_state   <= w_needs_shift ? S_SHIFT : S_DONE;
            r_valid   <= ~w_needs_shift;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_man   <= w_man_shl;
                    r_exp   <= w_exp_dec;
                    r_shift <= r_shift + w_k;
                    if (w_man_shl[NF]) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (OutReady) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign InReady    = w_in_ready;
    assign OutValid   = r_valid;
    assign OutSgn     = r_sgn;
    assign OutExp     = r_exp;
    assign OutMan     = r_man;
    assign OutShift   = r_shift;
    assign OutSubnorm = r_subnorm;
    assign OutZero    = r_zero;
    assign OutInf     = r_inf;
    assign OutNaN     = r_nan;
    assign OutSNaN    = r_snan;

endmodule

// File: doc/fpu_subnorm_normalizer.md
# fpu_subnorm_normalizer

Multi-cycle normalizer that sits directly downstream of the FPU operand unpacker. It takes one unpacked operand (sign, exponent widened to the largest precision, significand with its implicit bit, and class flags) over a valid/ready handshake. Subnormal significands are left-shifted, up to STEP bit positions per cycle, until the leading bit is 1, and the exponent is adjusted to match. The result is a normalized operand that the divide/sqrt and conversion stages consume without needing their own leading-zero logic. All other operand classes pass through with one cycle of latency.

## Interface
- NE, 11: exponent width of the largest supported precision.
- NF, 52: fraction width of the largest supported precision; the significand is NF+1 bits.
- STEP, 4: maximum left-shift per cycle; 1 ≤ STEP ≤ NF.
- SW, $clog2(NF+1): width of the shift-count output.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous abort; returns the block to IDLE.
- InValid  in  1  an operand is offered.
- InReady  out  1  the block can accept an operand this cycle.
- InSgn  in  1  sign.
- InExp  in  NE  biased exponent; subnormals arrive with exponent 1.
- InMan  in  NF+1  significand, implicit bit at [NF].
- InSubnorm, InZero, InInf, InNaN, InSNaN  in  1 each  class flags from the unpacker.
- OutValid  out  1  the result is valid.
- OutReady  in  1  the consumer accepts the result.
- OutSgn  out  1  sign, passed through.
- OutExp  out  NE+1  two's-complement biased exponent after adjustment.
- OutMan  out  NF+1  normalized significand.
- OutShift  out  SW  total left-shift applied.
- OutSubnorm, OutZero, OutInf, OutNaN, OutSNaN  out  1 each  flags, registered copies of the inputs.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- InReady = (state==IDLE) | (state==DONE & OutReady). InReady is forced to 0 while reset_n is low or Flush is high.
- Accept: on InValid & InReady, all inputs are registered.
  - OutExp is loaded as the zero-extended InExp, and OutShift is loaded as 0.
  - The next state is SHIFT if InSubnorm & (InMan != 0); otherwise it is DONE.
- Guard case: InSubnorm with InMan == 0 goes straight to DONE with no shift. The block must never hang.
- SHIFT, one step per cycle:
  - k = number of leading zeros in Man[NF:NF-STEP+1], capped at STEP.
  - Man <<= k, zero-fill.
  - Exp -= k in NE+1-bit two's complement.
  - Shift += k.
  - If the post-step Man[NF] is 1, go to DONE; otherwise stay in SHIFT.
- DONE:
  - OutValid = 1, and all outputs are held stable until OutReady is high.
  - On OutReady: if a new operand is accepted in the same cycle, follow the accept rule; otherwise go to IDLE.
- Zero, Inf, NaN (including badly-boxed NaN) and normal operands are not modified: OutMan = InMan and OutShift = 0.
- Arithmetic range:
  - The minimum OutExp is 1-NF, which fits in NE+1 signed bits because NF < 2^NE.
  - OutShift ≤ NF.
- Flush has the highest priority over accept, shift and output. On Flush the next state is IDLE and OutValid is deasserted the next cycle. An in-flight operand is discarded.

## Timing
- Reset: state=IDLE, OutValid=0, OutSgn=0, OutExp=0, OutMan=0, OutShift=0, all Out flags 0.
- Pass-through latency: an operand accepted at edge N has OutValid high in cycle N+1.
- Subnormal latency: with lz leading zeros in InMan, OutValid rises ceil(lz/STEP)+1 cycles after the accept edge.
  - Example: NF=52, STEP=4, lz=52 gives 14 cycles.
- Throughput:
  - Pass-through operands: one per cycle when OutReady is held high.
  - Subnormals: one per ceil(lz/STEP)+1 cycles.
- Handshake rules:
  - OutValid never drops without a transfer or a Flush.
  - The Out* signals do not change while OutValid & ~OutReady.
- Asynchronous reset mid-SHIFT clears everything immediately. After release, the first accept is allowed at the first rising edge at which reset_n is high.

## Test plan
All scenarios use NE=11, NF=52, STEP=4.
- Normal 1.0: InExp=0x3FF, InMan=1<<52 → one cycle later OutExp=0x3FF, OutMan=1<<52, OutShift=0.
- Smallest subnormal: InExp=1, InMan=1, InSubnorm=1 → after 14 cycles OutMan=1<<52, OutExp=0xFCD (−51), OutShift=52, OutSubnorm=1.
- Subnormal with a single shift: InMan bit 51 set → OutValid after 2 cycles, OutExp=0, OutShift=1.
  - Also cover the guard case: InSubnorm=1, InMan=0 → OutValid after 1 cycle, OutShift=0.
- Backpressure:
  - Hold OutReady=0 for 5 cycles with a result pending → outputs stable and InReady=0 throughout.
  - Then raise OutReady with InValid=1 → transfer and new accept in the same cycle.
  - Then stream 8 normal operands → 8 results on 8 consecutive cycles.
- Flush in cycle 5 of the 14-cycle subnormal → the next cycle is IDLE, OutValid=0, InReady=1, and no stale result ever appears.
- reset_n pulsed low during SHIFT → all outputs 0 immediately. After release, a normal operand completes with 1-cycle latency.
